// File: rtl/param_serializer_pkg.sv
// Shared types and helpers for param_serializer: FSM state encoding and
// the channel-index width calculation.
package param_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    SEND = 2'd2
  } state_t;

  // Width of a channel index; a single channel still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_serializer.sv
// Captures CHANNELS words of WIDTH bits on start and streams them over a
// valid/ready interface, optionally preceded by a constant TAG header beat.
module param_serializer
  import param_serializer_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned TAG      = 1,
  parameter bit          HEADER   = 1'b1,
  localparam int unsigned IDXW    = idx_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      start,
  output logic                      busy,
  output logic [WIDTH-1:0]          out_data,
  output logic [IDXW-1:0]           out_chan,
  output logic                      out_hdr,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      done
);

  localparam logic [WIDTH-1:0] TAG_W    = WIDTH'(TAG);
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(CHANNELS - 1);

  state_t            state, state_nxt;
  logic [IDXW-1:0]   idx, idx_nxt;
  logic              done_nxt;
  logic              capture;
  logic [WIDTH-1:0]  buffer [CHANNELS];
  logic [WIDTH-1:0]  sel_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      done  <= done_nxt;
    end
  end

  // Buffer has no reset: its contents are only observed after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        buffer[c] <= data_in[c*WIDTH +: WIDTH];
      end
    end
  end

  // Mux by explicit compare so non-power-of-two CHANNELS never indexes past the array.
  always_comb begin
    sel_word = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (idx == IDXW'(c)) sel_word = buffer[c];
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    capture   = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_hdr   = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    out_chan  = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          idx_nxt   = '0;
          state_nxt = HEADER ? HEAD : SEND;
        end
      end
      HEAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_hdr   = 1'b1;
        out_data  = TAG_W;
        if (out_ready) state_nxt = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = sel_word;
        out_chan  = idx;
        out_last  = (idx == LAST_IDX);
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + IDXW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_param_serializer.sv
// Directed bench for param_serializer covering three parameterisations:
// 32x2 with header, 10x3 without header, and 1x1 with a truncated tag.
module tb_param_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 32-bit x 2 channels, header on
  logic [63:0] d32 = '0;
  logic        s32 = 1'b0, r32 = 1'b1;
  logic        b32, h32, l32, v32, dn32;
  logic [31:0] o32;
  logic [0:0]  c32;

  // 10-bit x 3 channels, no header
  logic [29:0] d10 = '0;
  logic        s10 = 1'b0, r10 = 1'b1;
  logic        b10, h10, l10, v10, dn10;
  logic [9:0]  o10;
  logic [1:0]  c10;

  // 1-bit x 1 channel, header on, TAG=3 truncates to 1
  logic [0:0]  d1 = '0;
  logic        s1 = 1'b0, r1 = 1'b1;
  logic        b1, h1, l1, v1, dn1;
  logic [0:0]  o1;
  logic [0:0]  c1;

  param_serializer #(.WIDTH(32), .CHANNELS(2), .TAG(1), .HEADER(1'b1)) u32 (
    .clk(clk), .rst(rst), .data_in(d32), .start(s32), .busy(b32),
    .out_data(o32), .out_chan(c32), .out_hdr(h32), .out_last(l32),
    .out_valid(v32), .out_ready(r32), .done(dn32));

  param_serializer #(.WIDTH(10), .CHANNELS(3), .TAG(5), .HEADER(1'b0)) u10 (
    .clk(clk), .rst(rst), .data_in(d10), .start(s10), .busy(b10),
    .out_data(o10), .out_chan(c10), .out_hdr(h10), .out_last(l10),
    .out_valid(v10), .out_ready(r10), .done(dn10));

  param_serializer #(.WIDTH(1), .CHANNELS(1), .TAG(3), .HEADER(1'b1)) u1 (
    .clk(clk), .rst(rst), .data_in(d1), .start(s1), .busy(b1),
    .out_data(o1), .out_chan(c1), .out_hdr(h1), .out_last(l1),
    .out_valid(v1), .out_ready(r1), .done(dn1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge; all driving and sampling happen here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full beat check: {valid, hdr, last, busy, done} packed plus chan and data.
  task automatic beat32(input string tag, input logic [4:0] flags,
                        input logic [31:0] chan, input logic [31:0] data);
    chk({tag, ".flags"}, {27'd0, v32, h32, l32, b32, dn32}, {27'd0, flags});
    chk({tag, ".chan"}, 32'(c32), chan);
    chk({tag, ".data"}, o32, data);
  endtask

  task automatic beat10(input string tag, input logic [4:0] flags,
                        input logic [31:0] chan, input logic [31:0] data);
    chk({tag, ".flags"}, {27'd0, v10, h10, l10, b10, dn10}, {27'd0, flags});
    chk({tag, ".chan"}, 32'(c10), chan);
    chk({tag, ".data"}, 32'(o10), data);
  endtask

  task automatic beat1(input string tag, input logic [4:0] flags,
                       input logic [31:0] chan, input logic [31:0] data);
    chk({tag, ".flags"}, {27'd0, v1, h1, l1, b1, dn1}, {27'd0, flags});
    chk({tag, ".chan"}, 32'(c1), chan);
    chk({tag, ".data"}, 32'(o1), data);
  endtask

  // flags = {valid, hdr, last, busy, done}
  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_HDR  = 5'b11010;
  localparam logic [4:0] F_MID  = 5'b10010;
  localparam logic [4:0] F_LAST = 5'b10110;
  localparam logic [4:0] F_DONE = 5'b00001;

  initial begin
    // reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    beat32("rst32", F_IDLE, 0, 0);
    beat10("rst10", F_IDLE, 0, 0);
    beat1("rst1", F_IDLE, 0, 0);

    // basic 32x2 frame with header, ready held high
    d32 = {32'h0000_000B, 32'h0000_000A};
    s32 = 1'b1;
    tick();
    s32 = 1'b0;
    beat32("t1.hdr", F_HDR, 0, 32'h1);
    tick();
    beat32("t1.ch0", F_MID, 0, 32'hA);
    tick();
    beat32("t1.ch1", F_LAST, 1, 32'hB);
    tick();
    beat32("t1.done", F_DONE, 0, 0);
    tick();
    beat32("t1.after", F_IDLE, 0, 0);

    // 10x3 without header
    d10 = {10'h0AA, 10'h3C5, 10'h123};
    s10 = 1'b1;
    tick();
    s10 = 1'b0;
    beat10("t2.ch0", F_MID, 0, 32'h123);
    tick();
    beat10("t2.ch1", F_MID, 1, 32'h3C5);
    tick();
    beat10("t2.ch2", F_LAST, 2, 32'h0AA);
    tick();
    beat10("t2.done", F_DONE, 0, 0);

    // backpressure on ch1 for 4 cycles
    d32 = {32'hDEAD_BEEF, 32'h1234_5678};
    s32 = 1'b1;
    tick();
    s32 = 1'b0;
    beat32("t3.hdr", F_HDR, 0, 32'h1);
    tick();
    beat32("t3.ch0", F_MID, 0, 32'h1234_5678);
    tick();
    r32 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat32($sformatf("t3.hold%0d", i), F_LAST, 1, 32'hDEAD_BEEF);
      tick();
    end
    beat32("t3.hold4", F_LAST, 1, 32'hDEAD_BEEF);
    r32 = 1'b1;
    tick();
    beat32("t3.done", F_DONE, 0, 0);

    // capture isolation and ignored mid-frame start
    d32 = {32'h0000_2222, 32'h0000_1111};
    s32 = 1'b1;
    tick();
    s32 = 1'b0;
    d32 = '0;
    beat32("t4.hdr", F_HDR, 0, 32'h1);
    s32 = 1'b1;
    tick();
    s32 = 1'b0;
    beat32("t4.ch0", F_MID, 0, 32'h1111);
    tick();
    beat32("t4.ch1", F_LAST, 1, 32'h2222);
    tick();
    beat32("t4.done", F_DONE, 0, 0);
    tick();
    beat32("t4.noqueue", F_IDLE, 0, 0);

    // reset during ch1 beat, then a fresh frame
    d32 = {32'h0000_4444, 32'h0000_3333};
    s32 = 1'b1;
    tick();
    s32 = 1'b0;
    tick();
    tick();
    beat32("t5.ch1", F_LAST, 1, 32'h4444);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    beat32("t5.rst", F_IDLE, 0, 0);
    tick();
    beat32("t5.nodone", F_IDLE, 0, 0);
    d32 = {32'h0000_0066, 32'h0000_0055};
    s32 = 1'b1;
    tick();
    s32 = 1'b0;
    beat32("t5.hdr", F_HDR, 0, 32'h1);
    tick();
    beat32("t5.ch0", F_MID, 0, 32'h55);
    tick();
    beat32("t5.ch1b", F_LAST, 1, 32'h66);
    tick();
    beat32("t5.done", F_DONE, 0, 0);

    // single-channel, 1-bit, truncated tag, back-to-back start in done cycle
    d1 = 1'b0;
    s1 = 1'b1;
    tick();
    s1 = 1'b0;
    beat1("t6.hdr", F_HDR, 0, 32'h1);
    tick();
    beat1("t6.ch0", F_LAST, 0, 32'h0);
    tick();
    beat1("t6.done", F_DONE, 0, 0);
    d1 = 1'b1;
    s1 = 1'b1;
    tick();
    s1 = 1'b0;
    beat1("t6.hdr2", F_HDR, 0, 32'h1);
    tick();
    beat1("t6.ch0b", F_LAST, 0, 32'h1);
    tick();
    beat1("t6.done2", F_DONE, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
